matrix_layer_scheduler: RTL and testbench

- Time-multiplexes the single 8x16 LED matrix between three sprite layers: dino, obstacles and score.
- Each layer supplies a row mask (active-high) and a column mask (active-low).
- Round-robin slots of fixed dwell, with a blanking gap between slots to suppress ghosting.
- Sits between the sprite generators and the matrix pins; the matrix sees only its registered row/col.

---
 rtl/matrix_layer_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_matrix_layer_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_layer_scheduler.sv
// Round-robin time-multiplexer of the dino, obstacle and score layers onto one 8x16 LED matrix.
// Optional sticky dino/obstacle overlap detector is built when COLLIDE_DETECT_EN is defined.
module matrix_layer_scheduler #(
    parameter int DWELL = 250,
    parameter int BLANK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dino_row,
    input  logic [15:0] dino_col,
    input  logic        dino_vld,
    input  logic [7:0]  obs_row,
    input  logic [15:0] obs_col,
    input  logic        obs_vld,
    input  logic [7:0]  score_row,
    input  logic [15:0] score_col,
    input  logic        score_vld,
    output logic [7:0]  row,
    output logic [15:0] col,
    output logic [2:0]  grant,
    output logic        frame_tick,
    output logic        collision
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;

    state_t         state_reg, state_next;
    logic [1:0]     ptr_reg, ptr_next;
    logic [DW-1:0]  dwell_reg, dwell_next;
    logic [BW-1:0]  blank_reg, blank_next;
    logic [2:0]     grant_reg, grant_next;
    logic [7:0]     row_reg, row_next;
    logic [15:0]    col_reg, col_next;
    logic           tick_reg, tick_next;

    logic [2:0]     vld;
    logic [7:0]     layer_row [3];
    logic [15:0]    layer_col [3];
    logic [7:0]     row_masked [3];
    logic [15:0]    col_masked [3];
    logic [15:0]    col_act;
    logic [2:0]     higher;
    logic [1:0]     ptr_after;
    logic           slot_end;

    assign vld          = {score_vld, obs_vld, dino_vld};
    assign layer_row[0] = dino_row;
    assign layer_row[1] = obs_row;
    assign layer_row[2] = score_row;
    assign layer_col[0] = dino_col;
    assign layer_col[1] = obs_col;
    assign layer_col[2] = score_col;

    // First requesting layer in the order base, base+1, base+2 (mod 3), one-hot.
    function automatic logic [2:0] pick(input logic [1:0] base, input logic [2:0] req);
        logic [2:0] won;
        logic [2:0] idx;
        logic       found;
        won   = '0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, base} + 3'(k);
            if (idx >= 3'd3)
                idx = idx - 3'd3;
            if (!found && req[idx[1:0]]) begin
                won[idx[1:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return won;
    endfunction

    // Only the layer granted for the coming cycle reaches the pins, so layers never mix.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_layer
            assign row_masked[gi] = layer_row[gi] & {8{grant_next[gi]}};
            assign col_masked[gi] = ~layer_col[gi] & {16{grant_next[gi]}};
            if (gi == 0) begin : g_first
                assign higher[gi] = 1'b0;
            end else begin : g_rest
                assign higher[gi] = |grant_reg[gi-1:0];
            end
        end
    endgenerate

    assign ptr_after = grant_reg[0] ? 2'd1 : (grant_reg[1] ? 2'd2 : 2'd0);
    assign slot_end  = (dwell_reg == '0) || !(|(grant_reg & vld));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            dwell_reg <= '0;
            blank_reg <= '0;
            grant_reg <= '0;
            row_reg   <= '0;
            col_reg   <= '1;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            dwell_reg <= dwell_next;
            blank_reg <= blank_next;
            grant_reg <= grant_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            tick_reg  <= tick_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        dwell_next = dwell_reg;
        blank_next = blank_reg;
        grant_next = grant_reg;
        tick_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|vld) begin
                    grant_next = pick(ptr_reg, vld);
                    dwell_next = DWELL_LOAD;
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (slot_end) begin
                    ptr_next   = ptr_after;
                    tick_next  = ~|(vld & higher);
                    grant_next = '0;
                    if (BLANK > 0) begin
                        blank_next = BLANK_LOAD;
                        state_next = GAP;
                    end else if (|vld) begin
                        grant_next = pick(ptr_after, vld);
                        dwell_next = DWELL_LOAD;
                        state_next = SHOW;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    dwell_next = dwell_reg - DW'(1);
                end
            end
            GAP: begin
                grant_next = '0;
                if (blank_reg == '0) begin
                    if (|vld) begin
                        grant_next = pick(ptr_reg, vld);
                        dwell_next = DWELL_LOAD;
                        state_next = SHOW;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    blank_next = blank_reg - BW'(1);
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        row_next = '0;
        col_act  = '0;
        for (int i = 0; i < 3; i++) begin
            row_next = row_next | row_masked[i];
            col_act  = col_act | col_masked[i];
        end
        col_next = ~col_act;
    end

    assign row        = row_reg;
    assign col        = col_reg;
    assign grant      = grant_reg;
    assign frame_tick = tick_reg;

`ifdef COLLIDE_DETECT_EN
    logic collision_reg;
    logic overlap;

    // Overlap is judged on raw layer inputs, whatever is currently on the matrix.
    assign overlap = dino_vld & obs_vld & (|(dino_row & obs_row)) & (|(~dino_col & ~obs_col));

    always_ff @(posedge clk) begin
        if (rst)
            collision_reg <= 1'b0;
        else if (overlap)
            collision_reg <= 1'b1;
    end

    assign collision = collision_reg;
`else
    assign collision = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_layer_scheduler.sv
// Bench for matrix_layer_scheduler: a BLANK=2 and a BLANK=0 instance checked against a slot-level model.
`timescale 1ns/1ps
module tb_matrix_layer_scheduler;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dino_row, obs_row, score_row;
    logic [15:0] dino_col, obs_col, score_col;
    logic        dino_vld, obs_vld, score_vld;

    logic [7:0]  row_a, row_b;
    logic [15:0] col_a, col_b;
    logic [2:0]  grant_a, grant_b;
    logic        tick_a, tick_b, coll_a, coll_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    matrix_layer_scheduler #(.DWELL(DWELL), .BLANK(2)) dut_a (
        .clk(clk), .rst(rst),
        .dino_row(dino_row), .dino_col(dino_col), .dino_vld(dino_vld),
        .obs_row(obs_row), .obs_col(obs_col), .obs_vld(obs_vld),
        .score_row(score_row), .score_col(score_col), .score_vld(score_vld),
        .row(row_a), .col(col_a), .grant(grant_a), .frame_tick(tick_a), .collision(coll_a)
    );

    matrix_layer_scheduler #(.DWELL(DWELL), .BLANK(0)) dut_b (
        .clk(clk), .rst(rst),
        .dino_row(dino_row), .dino_col(dino_col), .dino_vld(dino_vld),
        .obs_row(obs_row), .obs_col(obs_col), .obs_vld(obs_vld),
        .score_row(score_row), .score_col(score_col), .score_vld(score_vld),
        .row(row_b), .col(col_b), .grant(grant_b), .frame_tick(tick_b), .collision(coll_b)
    );

    // Slot-level model: mode 0 idle, 1 lit (age = lit cycles so far), 2 off gap (gap = off cycles left).
    typedef struct packed {
        int          mode;
        int          layer;
        int          age;
        int          gap;
        int          ptr;
        logic [2:0]  grant;
        logic [7:0]  row;
        logic [15:0] col;
        logic        tick;
        logic        coll;
    } model_t;

    model_t ma, mb;
    logic [28:0] obs_a, obs_b, exp_a, exp_b;

    assign obs_a = {grant_a, row_a, col_a, tick_a, coll_a};
    assign obs_b = {grant_b, row_b, col_b, tick_b, coll_b};
    assign exp_a = {ma.grant, ma.row, ma.col, ma.tick, ma.coll};
    assign exp_b = {mb.grant, mb.row, mb.col, mb.tick, mb.coll};

    function automatic model_t step(input model_t m, input int blank, input logic rs,
                                    input logic [2:0] v, input logic [23:0] rows, input logic [47:0] cols);
        model_t n;
        bit     start;
        bit     found;
        int     idx;
        n      = m;
        n.tick = 1'b0;
        start  = 1'b0;
        if (rs) begin
            n.mode = 0; n.layer = 0; n.age = 0; n.gap = 0; n.ptr = 0;
            n.grant = 3'b000; n.row = 8'h00; n.col = 16'hFFFF; n.coll = 1'b0;
            return n;
        end
`ifdef COLLIDE_DETECT_EN
        if (v[0] && v[1] && (rows[7:0] & rows[15:8]) != 8'h00 && (~cols[15:0] & ~cols[31:16]) != 16'h0000)
            n.coll = 1'b1;
`endif
        n.grant = 3'b000; n.row = 8'h00; n.col = 16'hFFFF;
        case (m.mode)
            0: start = 1'b1;
            1: begin
                if (m.age >= DWELL || !v[m.layer]) begin
                    n.tick = 1'b1;
                    for (int i = m.layer + 1; i < 3; i++)
                        if (v[i]) n.tick = 1'b0;
                    n.ptr = (m.layer + 1) % 3;
                    if (blank > 0) begin
                        n.mode = 2;
                        n.gap  = blank;
                    end else begin
                        start = 1'b1;
                    end
                end else begin
                    n.age   = m.age + 1;
                    n.grant = 3'b001 << m.layer;
                    n.row   = rows[m.layer*8 +: 8];
                    n.col   = cols[m.layer*16 +: 16];
                end
            end
            default: begin
                n.gap = m.gap - 1;
                if (n.gap == 0) start = 1'b1;
            end
        endcase
        if (start) begin
            found = 1'b0;
            for (int k = 0; k < 3; k++) begin
                idx = (n.ptr + k) % 3;
                if (!found && v[idx]) begin
                    found   = 1'b1;
                    n.mode  = 1;
                    n.layer = idx;
                    n.age   = 1;
                    n.grant = 3'b001 << idx;
                    n.row   = rows[idx*8 +: 8];
                    n.col   = cols[idx*16 +: 16];
                end
            end
            if (!found) n.mode = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, 2, rst, {score_vld, obs_vld, dino_vld},
                   {score_row, obs_row, dino_row}, {score_col, obs_col, dino_col});
        mb <= step(mb, 0, rst, {score_vld, obs_vld, dino_vld},
                   {score_row, obs_row, dino_row}, {score_col, obs_col, dino_col});
    end

    task automatic rand_data();
        dino_row  = 8'($urandom);
        obs_row   = 8'($urandom);
        score_row = 8'($urandom);
        dino_col  = 16'($urandom);
        obs_col   = 16'($urandom);
        score_col = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {score_vld, obs_vld, dino_vld} = 3'b111;
        rand_data();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== {3'b000, 8'h00, 16'hFFFF, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_a cyc %0d: got %h want %h", i, obs_a, {3'b000, 8'h00, 16'hFFFF, 2'b00});
            end
            checks++;
            if (obs_b !== {3'b000, 8'h00, 16'hFFFF, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_b cyc %0d: got %h want %h", i, obs_b, {3'b000, 8'h00, 16'hFFFF, 2'b00});
            end
            rand_data();
        end
        $display("test_reset done");
    endtask

    task automatic test_rotation();
        logic [2:0] g;
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            g = (i < 4) ? 3'b001 : (i < 6) ? 3'b000 : (i < 10) ? 3'b010 :
                (i < 12) ? 3'b000 : (i < 16) ? 3'b100 : 3'b000;
            checks++;
            if (grant_a !== g) begin
                errors++;
                $display("FAIL rotation_grant cyc %0d: got %b want %b", i, grant_a, g);
            end
            checks++;
            if (tick_a !== (i == 16)) begin
                errors++;
                $display("FAIL rotation_tick cyc %0d: got %b want %b", i, tick_a, (i == 16));
            end
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL rotation_model_a cyc %0d: got %h want %h", i, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL rotation_model_b cyc %0d: got %h want %h", i, obs_b, exp_b);
            end
            rand_data();
        end
        $display("test_rotation done");
    endtask

    task automatic test_lone_layer();
        bit lit;
        rst = 1'b1;
        rand_data();
        {score_vld, obs_vld, dino_vld} = 3'b010;
        obs_row = 8'h03;
        obs_col = 16'h9FFF;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            lit = (i % 6) < 4;
            checks++;
            if ({grant_a, row_a, col_a, tick_a} !== (lit ? {3'b010, 8'h03, 16'h9FFF, 1'b0}
                                                         : {3'b000, 8'h00, 16'hFFFF, (i % 6) == 4})) begin
                errors++;
                $display("FAIL lone_layer cyc %0d: got grant=%b row=%h col=%h tick=%b lit_wanted=%b",
                         i, grant_a, row_a, col_a, tick_a, lit);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL lone_model_b cyc %0d: got %h want %h", i, obs_b, exp_b);
            end
        end
        $display("test_lone_layer done");
    endtask

    task automatic test_early_end();
        logic [2:0] g;
        rst = 1'b1;
        rand_data();
        {score_vld, obs_vld, dino_vld} = 3'b011;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            g = (i < 2) ? 3'b001 : (i < 4) ? 3'b000 : 3'b010;
            if (i < 5) begin
                checks++;
                if ({grant_a, tick_a} !== {g, 1'b0} || (g == 3'b000 && row_a !== 8'h00)) begin
                    errors++;
                    $display("FAIL early_end cyc %0d: got grant=%b tick=%b row=%h want grant=%b tick=0",
                             i, grant_a, tick_a, row_a, g);
                end
            end
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL early_model_a cyc %0d: got %h want %h", i, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL early_model_b cyc %0d: got %h want %h", i, obs_b, exp_b);
            end
            rand_data();
            if (i == 1) dino_vld = 1'b0;
        end
        $display("test_early_end done");
    endtask

    task automatic test_back_to_back();
        logic [2:0] g;
        rst = 1'b1;
        rand_data();
        {score_vld, obs_vld, dino_vld} = 3'b101;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            g = (i < 4) ? 3'b001 : (i < 8) ? 3'b100 : 3'b001;
            checks++;
            if ({grant_b, tick_b} !== {g, (i == 8)}) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got grant=%b tick=%b want grant=%b tick=%b",
                         i, grant_b, tick_b, g, (i == 8));
            end
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL b2b_model_a cyc %0d: got %h want %h", i, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL b2b_model_b cyc %0d: got %h want %h", i, obs_b, exp_b);
            end
            rand_data();
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_idle();
        rst = 1'b1;
        rand_data();
        {score_vld, obs_vld, dino_vld} = 3'b001;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i >= 4 && i <= 9) begin
                checks++;
                if ({grant_a, row_a, col_a, grant_b, row_b, col_b} !==
                    {3'b000, 8'h00, 16'hFFFF, 3'b000, 8'h00, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL idle_off cyc %0d: got a=%b/%h/%h b=%b/%h/%h want 000/00/ffff",
                             i, grant_a, row_a, col_a, grant_b, row_b, col_b);
                end
            end
            if (i == 10) begin
                checks++;
                if ({grant_a, grant_b} !== {3'b010, 3'b010}) begin
                    errors++;
                    $display("FAIL idle_wake: got a=%b b=%b want 010", grant_a, grant_b);
                end
            end
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++;
                $display("FAIL idle_model cyc %0d: got %h/%h want %h/%h", i, obs_a, obs_b, exp_a, exp_b);
            end
            rand_data();
            if (i == 3) {score_vld, obs_vld, dino_vld} = 3'b000;
            if (i == 9) obs_vld = 1'b1;
        end
        $display("test_idle done");
    endtask

    task automatic test_collision();
        logic want;
`ifdef COLLIDE_DETECT_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        rst = 1'b1;
        {score_vld, obs_vld, dino_vld} = 3'b011;
        dino_row = 8'h02; dino_col = 16'hFFEF;
        obs_row  = 8'h03; obs_col  = 16'hFFCF;
        score_row = 8'h00; score_col = 16'hFFFF;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({coll_a, coll_b} !== {want, want}) begin
                errors++;
                $display("FAIL collision_hold cyc %0d: got %b/%b want %b", i, coll_a, coll_b, want);
            end
            {score_vld, obs_vld, dino_vld} = 3'b000;
            dino_row = 8'h00; obs_row = 8'h00;
            dino_col = 16'hFFFF; obs_col = 16'hFFFF;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({coll_a, coll_b} !== 2'b00) begin
            errors++;
            $display("FAIL collision_clear: got %b/%b want 0", coll_a, coll_b);
        end
        rst = 1'b0;
        $display("test_collision done");
    endtask

    task automatic test_random();
        rst = 1'b1;
        rand_data();
        {score_vld, obs_vld, dino_vld} = 3'($urandom);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== exp_a) begin
                errors++;
                $display("FAIL random_model_a cyc %0d: got %h want %h", i, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL random_model_b cyc %0d: got %h want %h", i, obs_b, exp_b);
            end
            rand_data();
            if ($urandom_range(7) == 0) dino_vld  = ~dino_vld;
            if ($urandom_range(7) == 0) obs_vld   = ~obs_vld;
            if ($urandom_range(7) == 0) score_vld = ~score_vld;
            rst = ($urandom_range(99) == 0);
        end
        rst = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_lone_layer();
        test_early_end();
        test_back_to_back();
        test_idle();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
